emac_tx_adapter: RTL and testbench

- Parametrised user-side TX adapter between the Avalon-style ff_tx_* packet source and the MAC user TX interface (Tx_mac_*), running on Clk_user.
- Replaces the plain register stage with an internal DEPTH-word buffer, credit-style ready, and a start threshold to avoid mid-frame underflow.
- Enforces sop/eop framing: overflow, upstream error and protocol violations terminate the frame cleanly with an error-marked eop word.

---
 rtl/emac_tx_adapter_pkg.sv | 28 ++
 rtl/emac_tx_sfifo.sv | 70 +++++++
 rtl/emac_tx_adapter.sv | 266 ++++++++++++++++++++++++++
 tb/tb_emac_tx_adapter.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/emac_tx_adapter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : emac_tx_adapter_pkg
// Purpose  : Shared constants for the EMAC user-side TX adapter: input FSM
//            state encodings and the bit layout of a buffered entry.
// Revision : 1.0 - initial release
// ============================================================================
package emac_tx_adapter_pkg;

  // Input-side framing FSM encodings
  localparam logic [1:0] c_ST_IDLE    = 2'd0;
  localparam logic [1:0] c_ST_FRAME   = 2'd1;
  localparam logic [1:0] c_ST_TERM    = 2'd2;
  localparam logic [1:0] c_ST_DISCARD = 2'd3;

  // Buffer entry layout, LSB first: err, eop, sop, mod[MOD_W], data[DATA_W]
  localparam int c_ENT_ERR = 0;
  localparam int c_ENT_EOP = 1;
  localparam int c_ENT_SOP = 2;
  localparam int c_ENT_MOD = 3;

  // Total entry width for a given data / modulo width
  function automatic int ent_width(input int data_w, input int mod_w);
    return data_w + mod_w + 3;
  endfunction

endpackage
`default_nettype wire

// File: rtl/emac_tx_sfifo.sv
`default_nettype none
// ============================================================================
// Module   : emac_tx_sfifo
// Purpose  : Single-clock synchronous FIFO with occupancy count and the
//            next-cycle count. Head word is presented combinationally.
// Revision : 1.0 - initial release
// ============================================================================
module emac_tx_sfifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_wr_en,
  input  logic [WIDTH-1:0]      i_wr_data,
  input  logic                  i_rd_en,
  output logic [WIDTH-1:0]      o_rd_data,
  output logic [DEPTH_LOG2:0]   o_count,
  output logic [DEPTH_LOG2:0]   o_count_next
);

  localparam int                c_DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] c_FULL = (DEPTH_LOG2 + 1)'(c_DEPTH);

  logic [WIDTH-1:0]      r_mem [c_DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic [DEPTH_LOG2:0]   w_count_nxt;
  logic                  w_do_wr;
  logic                  w_do_rd;

  // Writes into a full FIFO and reads from an empty one are ignored
  assign w_do_wr = i_wr_en & (r_count != c_FULL);
  assign w_do_rd = i_rd_en & (r_count != '0);

  // Occupancy update; simultaneous write and read leave it unchanged
  always_comb begin
    w_count_nxt = r_count;
    case ({w_do_wr, w_do_rd})
      2'b10:   w_count_nxt = r_count + 1'b1;
      2'b01:   w_count_nxt = r_count - 1'b1;
      default: w_count_nxt = r_count;
    endcase
  end

  // Pointer and count state; pointers wrap naturally at the power-of-two depth
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_nxt;
    end
  end

  // Storage array; contents need no reset since the count gates visibility
  always_ff @(posedge clk) begin
    if (w_do_wr) r_mem[r_wr_ptr] <= i_wr_data;
  end

  assign o_rd_data    = r_mem[r_rd_ptr];
  assign o_count      = r_count;
  assign o_count_next = w_count_nxt;

endmodule
`default_nettype wire

// File: rtl/emac_tx_adapter.sv
`default_nettype none
// ============================================================================
// Module   : emac_tx_adapter
// Purpose  : User-side TX adapter between the ff_tx_* packet source and the
//            MAC Tx_mac_* interface. Buffers words, gates frame start on a
//            threshold, and closes broken frames with an error-marked eop.
// Revision : 1.0 - initial release
// ============================================================================
module emac_tx_adapter
  import emac_tx_adapter_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int MOD_W      = 2,
  parameter int DEPTH_LOG2 = 3,
  parameter int AFULL_THR  = 2,
  parameter int START_THR  = 4,
  parameter int SEPTY_THR  = 1
) (
  input  logic                  Clk_user,
  input  logic                  Reset,
  input  logic [DATA_W-1:0]     ff_tx_data,
  input  logic [MOD_W-1:0]      ff_tx_mod,
  input  logic                  ff_tx_sop,
  input  logic                  ff_tx_eop,
  input  logic                  ff_tx_wren,
  input  logic                  ff_tx_err,
  output logic                  ff_tx_rdy,
  output logic                  ff_tx_septy,
  output logic                  tx_ff_uflow,
  output logic                  tx_ff_oflow,
  output logic                  tx_ff_perr,
  input  logic                  Tx_mac_wa,
  output logic                  Tx_mac_wr,
  output logic [DATA_W-1:0]     Tx_mac_data,
  output logic [MOD_W-1:0]      Tx_mac_BE,
  output logic                  Tx_mac_sop,
  output logic                  Tx_mac_eop,
  output logic                  Tx_mac_err,
  output logic [DEPTH_LOG2:0]   fifo_level
);

  localparam int                  c_ENT_W  = ent_width(DATA_W, MOD_W);
  localparam int                  c_DATA   = c_ENT_MOD + MOD_W;
  localparam int                  c_DEPTH  = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] c_FULL   = (DEPTH_LOG2 + 1)'(c_DEPTH);
  localparam logic [31:0]         c_DEPTH32 = 32'(c_DEPTH);
  localparam logic [31:0]         c_AFULL  = 32'(AFULL_THR);
  localparam logic [31:0]         c_START  = 32'(START_THR);
  localparam logic [31:0]         c_SEPTY  = 32'(SEPTY_THR);

  // ---------------------------------------------------------------- state
  logic [1:0]              r_state;
  logic                    r_term_eop;   // frame's eop already seen while terminating
  logic                    r_rdy;
  logic                    r_septy;
  logic                    r_uflow;
  logic                    r_oflow;
  logic                    r_perr;
  logic                    r_in_frame;
  logic [DEPTH_LOG2:0]     r_eop_cnt;
  logic                    r_mac_wr;
  logic [DATA_W-1:0]       r_mac_data;
  logic [MOD_W-1:0]        r_mac_be;
  logic                    r_mac_sop;
  logic                    r_mac_eop;
  logic                    r_mac_err;

  // ---------------------------------------------------------------- wires
  logic                    w_accept;
  logic                    w_drop;
  logic [1:0]              w_state_nxt;
  logic                    w_term_eop_nxt;
  logic                    w_wr_en;
  logic [DATA_W-1:0]       w_wr_data;
  logic [MOD_W-1:0]        w_wr_mod;
  logic                    w_wr_sop;
  logic                    w_wr_eop;
  logic                    w_wr_err;
  logic                    w_perr;
  logic                    w_oflow;
  logic [c_ENT_W-1:0]      w_wr_entry;
  logic [c_ENT_W-1:0]      w_head;
  logic [DEPTH_LOG2:0]     w_count;
  logic [DEPTH_LOG2:0]     w_count_nxt;
  logic                    w_poppable;
  logic                    w_pop;
  logic                    w_head_sop;
  logic                    w_head_eop;
  logic                    w_head_err;
  logic [MOD_W-1:0]        w_head_mod;
  logic [DATA_W-1:0]       w_head_data;
  logic [31:0]             w_free_nxt;

  assign w_accept = ff_tx_wren & r_rdy;
  assign w_drop   = ff_tx_wren & ~r_rdy;

  // Input framing FSM: decides what (if anything) is written this cycle
  always_comb begin
    w_state_nxt    = r_state;
    w_term_eop_nxt = r_term_eop;
    w_wr_en        = 1'b0;
    w_wr_data      = ff_tx_data;
    w_wr_mod       = ff_tx_mod;
    w_wr_sop       = ff_tx_sop;
    w_wr_eop       = ff_tx_eop | ff_tx_err;
    w_wr_err       = ff_tx_err;
    w_perr         = 1'b0;
    w_oflow        = 1'b0;
    case (r_state)
      c_ST_IDLE: begin
        if (w_accept) begin
          if (ff_tx_sop) begin
            w_wr_en = 1'b1;
            if (ff_tx_eop)      w_state_nxt = c_ST_IDLE;
            else if (ff_tx_err) w_state_nxt = c_ST_DISCARD;
            else                w_state_nxt = c_ST_FRAME;
          end else begin
            w_perr = 1'b1;
          end
        end else if (w_drop) begin
          w_oflow = 1'b1;
        end
      end
      c_ST_FRAME: begin
        if (w_accept) begin
          if (ff_tx_sop) begin
            // A new frame cut into the current one: close the old one
            w_perr         = 1'b1;
            w_state_nxt    = c_ST_TERM;
            w_term_eop_nxt = ff_tx_eop;
          end else begin
            w_wr_en = 1'b1;
            if (ff_tx_eop)      w_state_nxt = c_ST_IDLE;
            else if (ff_tx_err) w_state_nxt = c_ST_DISCARD;
          end
        end else if (w_drop) begin
          w_oflow        = 1'b1;
          w_state_nxt    = c_ST_TERM;
          w_term_eop_nxt = ff_tx_eop;
        end
      end
      c_ST_TERM: begin
        if (ff_tx_wren & ff_tx_eop) w_term_eop_nxt = 1'b1;
        if (w_count != c_FULL) begin
          w_wr_en   = 1'b1;
          w_wr_data = '0;
          w_wr_mod  = '0;
          w_wr_sop  = 1'b0;
          w_wr_eop  = 1'b1;
          w_wr_err  = 1'b1;
          if (r_term_eop | (ff_tx_wren & ff_tx_eop)) w_state_nxt = c_ST_IDLE;
          else                                       w_state_nxt = c_ST_DISCARD;
        end
      end
      c_ST_DISCARD: begin
        if (ff_tx_wren & ff_tx_eop) w_state_nxt = c_ST_IDLE;
      end
      default: w_state_nxt = c_ST_IDLE;
    endcase
  end

  assign w_wr_entry = {w_wr_data, w_wr_mod, w_wr_sop, w_wr_eop, w_wr_err};

  emac_tx_sfifo #(
    .WIDTH      (c_ENT_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk          (Clk_user),
    .rst          (Reset),
    .i_wr_en      (w_wr_en),
    .i_wr_data    (w_wr_entry),
    .i_rd_en      (w_pop),
    .o_rd_data    (w_head),
    .o_count      (w_count),
    .o_count_next (w_count_nxt)
  );

  assign w_head_err  = w_head[c_ENT_ERR];
  assign w_head_eop  = w_head[c_ENT_EOP];
  assign w_head_sop  = w_head[c_ENT_SOP];
  assign w_head_mod  = w_head[c_ENT_MOD +: MOD_W];
  assign w_head_data = w_head[c_DATA +: DATA_W];

  // A frame only starts once enough is buffered (or it is complete), so the
  // MAC is unlikely to starve mid-frame; once started it drains freely.
  assign w_poppable = (w_count != '0) &
                      (r_in_frame | (32'(w_count) >= c_START) |
                       (r_eop_cnt != '0) | (c_START == 32'd0));
  assign w_pop      = Tx_mac_wa & w_poppable;

  assign w_free_nxt = c_DEPTH32 - 32'(w_count_nxt);

  // Input-side state, credit-style ready and section-empty flag
  always_ff @(posedge Clk_user or posedge Reset) begin
    if (Reset) begin
      r_state    <= c_ST_IDLE;
      r_term_eop <= 1'b0;
      r_rdy      <= 1'b0;
      r_septy    <= 1'b0;
      r_oflow    <= 1'b0;
      r_perr     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_term_eop <= w_term_eop_nxt;
      r_rdy      <= w_free_nxt > c_AFULL;
      r_septy    <= 32'(w_count_nxt) <= c_SEPTY;
      r_oflow    <= w_oflow;
      r_perr     <= w_perr;
    end
  end

  // Number of complete frames (eop words) currently held in the buffer
  always_ff @(posedge Clk_user or posedge Reset) begin
    if (Reset) begin
      r_eop_cnt <= '0;
    end else begin
      case ({w_wr_en & w_wr_eop, w_pop & w_head_eop})
        2'b10:   r_eop_cnt <= r_eop_cnt + 1'b1;
        2'b01:   r_eop_cnt <= r_eop_cnt - 1'b1;
        default: r_eop_cnt <= r_eop_cnt;
      endcase
    end
  end

  // MAC-side output stage, in-frame tracking and underflow detection
  always_ff @(posedge Clk_user or posedge Reset) begin
    if (Reset) begin
      r_mac_wr   <= 1'b0;
      r_mac_data <= '0;
      r_mac_be   <= '0;
      r_mac_sop  <= 1'b0;
      r_mac_eop  <= 1'b0;
      r_mac_err  <= 1'b0;
      r_in_frame <= 1'b0;
      r_uflow    <= 1'b0;
    end else begin
      r_mac_wr <= w_pop;
      if (w_pop) begin
        r_mac_data <= w_head_data;
        r_mac_be   <= w_head_mod;
        r_mac_sop  <= w_head_sop;
        r_mac_eop  <= w_head_eop;
        r_mac_err  <= w_head_err;
        // eop wins so a single-word frame leaves the flag clear
        if (w_head_eop)      r_in_frame <= 1'b0;
        else if (w_head_sop) r_in_frame <= 1'b1;
      end
      r_uflow <= r_in_frame & Tx_mac_wa & (w_count == '0);
    end
  end

  assign ff_tx_rdy   = r_rdy;
  assign ff_tx_septy = r_septy;
  assign tx_ff_uflow = r_uflow;
  assign tx_ff_oflow = r_oflow;
  assign tx_ff_perr  = r_perr;
  assign Tx_mac_wr   = r_mac_wr;
  assign Tx_mac_data = r_mac_data;
  assign Tx_mac_BE   = r_mac_be;
  assign Tx_mac_sop  = r_mac_sop;
  assign Tx_mac_eop  = r_mac_eop;
  assign Tx_mac_err  = r_mac_err;
  assign fifo_level  = w_count;

endmodule
`default_nettype wire

// File: tb/tb_emac_tx_adapter.sv
`default_nettype none
// ============================================================================
// Module   : tb_emac_tx_adapter
// Purpose  : Directed self-checking bench for emac_tx_adapter. Instance A uses
//            the default start threshold, instance B is cut-through.
// Revision : 1.0 - initial release
// ============================================================================
module tb_emac_tx_adapter;

  logic        clk = 1'b0;
  logic        Reset = 1'b1;
  logic [31:0] ff_tx_data = '0;
  logic [1:0]  ff_tx_mod = '0;
  logic        ff_tx_sop = 1'b0;
  logic        ff_tx_eop = 1'b0;
  logic        ff_tx_wren = 1'b0;
  logic        ff_tx_err = 1'b0;
  logic        Tx_mac_wa = 1'b0;

  logic        rdy_a, septy_a, uflow_a, oflow_a, perr_a, wr_a, sop_a, eop_a, err_a;
  logic [31:0] data_a;
  logic [1:0]  be_a;
  logic [3:0]  level_a;
  logic        rdy_b, septy_b, uflow_b, oflow_b, perr_b, wr_b, sop_b, eop_b, err_b;
  logic [31:0] data_b;
  logic [1:0]  be_b;
  logic [3:0]  level_b;

  always #5 clk = ~clk;

  emac_tx_adapter u_dut_a (
    .Clk_user(clk), .Reset(Reset),
    .ff_tx_data(ff_tx_data), .ff_tx_mod(ff_tx_mod), .ff_tx_sop(ff_tx_sop),
    .ff_tx_eop(ff_tx_eop), .ff_tx_wren(ff_tx_wren), .ff_tx_err(ff_tx_err),
    .ff_tx_rdy(rdy_a), .ff_tx_septy(septy_a), .tx_ff_uflow(uflow_a),
    .tx_ff_oflow(oflow_a), .tx_ff_perr(perr_a), .Tx_mac_wa(Tx_mac_wa),
    .Tx_mac_wr(wr_a), .Tx_mac_data(data_a), .Tx_mac_BE(be_a),
    .Tx_mac_sop(sop_a), .Tx_mac_eop(eop_a), .Tx_mac_err(err_a),
    .fifo_level(level_a)
  );

  emac_tx_adapter #(.START_THR(0)) u_dut_b (
    .Clk_user(clk), .Reset(Reset),
    .ff_tx_data(ff_tx_data), .ff_tx_mod(ff_tx_mod), .ff_tx_sop(ff_tx_sop),
    .ff_tx_eop(ff_tx_eop), .ff_tx_wren(ff_tx_wren), .ff_tx_err(ff_tx_err),
    .ff_tx_rdy(rdy_b), .ff_tx_septy(septy_b), .tx_ff_uflow(uflow_b),
    .tx_ff_oflow(oflow_b), .tx_ff_perr(perr_b), .Tx_mac_wa(Tx_mac_wa),
    .Tx_mac_wr(wr_b), .Tx_mac_data(data_b), .Tx_mac_BE(be_b),
    .Tx_mac_sop(sop_b), .Tx_mac_eop(eop_b), .Tx_mac_err(err_b),
    .fifo_level(level_b)
  );

  typedef struct packed {
    logic [31:0] d;
    logic [1:0]  be;
    logic        sop;
    logic        eop;
    logic        err;
  } beat_t;

  beat_t       qa[$];
  beat_t       qb[$];
  int unsigned ca[$];
  int unsigned cb[$];
  int unsigned cyc = 0;
  int          n_uflow_a = 0;
  int          n_uflow_b = 0;
  int          n_perr_a  = 0;
  int          n_tests   = 0;
  int          n_fail    = 0;
  int unsigned last_edge = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Capture MAC-side beats and pulse counts just after each edge
  always @(posedge clk) begin
    #1;
    if (wr_a) begin qa.push_back({data_a, be_a, sop_a, eop_a, err_a}); ca.push_back(cyc); end
    if (wr_b) begin qb.push_back({data_b, be_b, sop_b, eop_b, err_b}); cb.push_back(cyc); end
    if (uflow_a) n_uflow_a++;
    if (uflow_b) n_uflow_b++;
    if (perr_a)  n_perr_a++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic beat_t beat_a(input int i);
    if (i < qa.size()) return qa[i];
    return '0;
  endfunction

  function automatic beat_t beat_b(input int i);
    if (i < qb.size()) return qb[i];
    return '0;
  endfunction

  function automatic int unsigned cyc_a(input int i);
    if (i < ca.size()) return ca[i];
    return 0;
  endfunction

  function automatic int unsigned cyc_b(input int i);
    if (i < cb.size()) return cb[i];
    return 0;
  endfunction

  task automatic send(input logic [31:0] d, input logic [1:0] m,
                      input logic s, input logic e, input logic er);
    ff_tx_data = d; ff_tx_mod = m; ff_tx_sop = s; ff_tx_eop = e; ff_tx_err = er;
    ff_tx_wren = 1'b1;
    @(posedge clk); #1;
    last_edge  = cyc;
    ff_tx_wren = 1'b0; ff_tx_sop = 1'b0; ff_tx_eop = 1'b0; ff_tx_err = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    int          base_a, base_b, u_a0, u_b0, p0;
    int unsigned sop_edge, eop_edge;
    beat_t       b;

    // ---------------- reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rdy",   64'(rdy_a),   64'd0);
    chk("reset_level", 64'(level_a), 64'd0);
    chk("reset_wr",    64'(wr_a),    64'd0);
    chk("reset_septy", 64'(septy_a), 64'd0);
    chk("reset_flags", 64'({uflow_a, oflow_a, perr_a}), 64'd0);
    Reset = 1'b0;
    #1;
    chk("rdy_before_edge", 64'(rdy_a), 64'd0);
    @(posedge clk); #1;
    chk("rdy_after_edge",   64'(rdy_a),   64'd1);
    chk("septy_after_edge", 64'(septy_a), 64'd1);

    // ---------------- 3-word frame, start gated by buffered eop
    Tx_mac_wa = 1'b1;
    base_a = qa.size(); base_b = qb.size();
    send(32'hA0, 2'd0, 1'b1, 1'b0, 1'b0); sop_edge = last_edge;
    send(32'hA1, 2'd0, 1'b0, 1'b0, 1'b0);
    send(32'hA2, 2'd2, 1'b0, 1'b1, 1'b0); eop_edge = last_edge;
    idle(8);
    chk("f1_count", 64'(qa.size() - base_a), 64'd3);
    b = beat_a(base_a);
    chk("f1_w0", 64'({b.d, b.sop, b.eop, b.err}), 64'({32'hA0, 1'b1, 1'b0, 1'b0}));
    b = beat_a(base_a + 1);
    chk("f1_w1", 64'({b.d, b.sop, b.eop}), 64'({32'hA1, 1'b0, 1'b0}));
    b = beat_a(base_a + 2);
    chk("f1_w2", 64'({b.d, b.be, b.sop, b.eop, b.err}), 64'({32'hA2, 2'd2, 1'b0, 1'b1, 1'b0}));
    chk("f1_start_at_eop", 64'(cyc_a(base_a)), 64'(eop_edge + 1));
    chk("f1_contiguous",   64'(cyc_a(base_a + 2) - cyc_a(base_a)), 64'd2);
    chk("f1_cut_through_latency", 64'(cyc_b(base_b)), 64'(sop_edge + 1));

    // ---------------- cut-through with input stall -> underflow pulses
    base_b = qb.size(); u_a0 = n_uflow_a; u_b0 = n_uflow_b;
    send(32'hB0, 2'd0, 1'b1, 1'b0, 1'b0);
    send(32'hB1, 2'd0, 1'b0, 1'b0, 1'b0);
    send(32'hB2, 2'd0, 1'b0, 1'b0, 1'b0);
    idle(2);
    send(32'hB3, 2'd0, 1'b0, 1'b0, 1'b0);
    send(32'hB4, 2'd0, 1'b0, 1'b0, 1'b0);
    send(32'hB5, 2'd1, 1'b0, 1'b1, 1'b0);
    idle(10);
    chk("uf_pulses_b", 64'(n_uflow_b - u_b0), 64'd2);
    chk("uf_pulses_a", 64'(n_uflow_a - u_a0), 64'd0);
    chk("uf_count_b",  64'(qb.size() - base_b), 64'd6);
    for (int i = 0; i < 6; i++) begin
      b = beat_b(base_b + i);
      chk($sformatf("uf_word%0d", i), 64'({b.d, b.sop, b.eop, b.err}),
          64'({32'hB0 + 32'(i), i == 0, i == 5, 1'b0}));
    end

    // ---------------- overflow with MAC stalled
    Tx_mac_wa = 1'b0;
    base_a = qa.size();
    for (int k = 0; k < 8; k++) begin
      send(32'hD0 + 32'(k), (k == 7) ? 2'd3 : 2'd0, k == 0, k == 7, 1'b0);
      if (k == 4) begin
        chk("of_level5", 64'(level_a), 64'd5);
        chk("of_rdy_at5", 64'(rdy_a), 64'd1);
      end
      if (k == 5) begin
        chk("of_level6", 64'(level_a), 64'd6);
        chk("of_rdy_low", 64'(rdy_a), 64'd0);
        chk("of_septy_low", 64'(septy_a), 64'd0);
      end
      if (k == 6) begin
        chk("of_pulse", 64'(oflow_a), 64'd1);
        chk("of_level_hold", 64'(level_a), 64'd6);
      end
      if (k == 7) chk("of_level_term", 64'(level_a), 64'd7);
    end
    Tx_mac_wa = 1'b1;
    idle(12);
    chk("of_count", 64'(qa.size() - base_a), 64'd7);
    for (int i = 0; i < 6; i++) begin
      b = beat_a(base_a + i);
      chk($sformatf("of_word%0d", i), 64'({b.d, b.sop, b.eop, b.err}),
          64'({32'hD0 + 32'(i), i == 0, 1'b0, 1'b0}));
    end
    b = beat_a(base_a + 6);
    chk("of_terminator", 64'({b.d, b.be, b.sop, b.eop, b.err}), 64'({32'h0, 2'd0, 1'b0, 1'b1, 1'b1}));
    chk("of_drained", 64'(level_a), 64'd0);
    chk("of_rdy_back", 64'(rdy_a), 64'd1);

    // ---------------- upstream error on word 2
    base_a = qa.size(); p0 = n_perr_a;
    send(32'hE0, 2'd0, 1'b1, 1'b0, 1'b0);
    send(32'hE1, 2'd0, 1'b0, 1'b0, 1'b1);
    send(32'hE2, 2'd0, 1'b0, 1'b0, 1'b0);
    send(32'hE3, 2'd0, 1'b0, 1'b0, 1'b0);
    send(32'hE4, 2'd1, 1'b0, 1'b1, 1'b0);
    idle(8);
    chk("er_count", 64'(qa.size() - base_a), 64'd2);
    b = beat_a(base_a);
    chk("er_w0", 64'({b.d, b.sop, b.eop, b.err}), 64'({32'hE0, 1'b1, 1'b0, 1'b0}));
    b = beat_a(base_a + 1);
    chk("er_w1", 64'({b.d, b.sop, b.eop, b.err}), 64'({32'hE1, 1'b0, 1'b1, 1'b1}));
    chk("er_no_perr", 64'(n_perr_a - p0), 64'd0);

    // ---------------- sop inside a frame
    base_a = qa.size(); p0 = n_perr_a;
    send(32'hF0, 2'd0, 1'b1, 1'b0, 1'b0);
    send(32'hF1, 2'd0, 1'b0, 1'b0, 1'b0);
    send(32'h60, 2'd0, 1'b1, 1'b0, 1'b0);
    chk("pe_pulse", 64'(perr_a), 64'd1);
    send(32'h61, 2'd0, 1'b0, 1'b0, 1'b0);
    send(32'h62, 2'd0, 1'b0, 1'b1, 1'b0);
    send(32'h70, 2'd0, 1'b1, 1'b0, 1'b0);
    send(32'h71, 2'd3, 1'b0, 1'b1, 1'b0);
    idle(10);
    chk("pe_count", 64'(qa.size() - base_a), 64'd5);
    chk("pe_pulses", 64'(n_perr_a - p0), 64'd1);
    b = beat_a(base_a + 1);
    chk("pe_w1", 64'({b.d, b.eop}), 64'({32'hF1, 1'b0}));
    b = beat_a(base_a + 2);
    chk("pe_term", 64'({b.d, b.sop, b.eop, b.err}), 64'({32'h0, 1'b0, 1'b1, 1'b1}));
    b = beat_a(base_a + 3);
    chk("pe_next_sop", 64'({b.d, b.sop, b.eop, b.err}), 64'({32'h70, 1'b1, 1'b0, 1'b0}));
    b = beat_a(base_a + 4);
    chk("pe_next_eop", 64'({b.d, b.be, b.eop, b.err}), 64'({32'h71, 2'd3, 1'b1, 1'b0}));

    // ---------------- reset in the middle of a frame
    Tx_mac_wa = 1'b0;
    for (int k = 0; k < 5; k++) send(32'h80 + 32'(k), 2'd0, k == 0, 1'b0, 1'b0);
    chk("rs_level5", 64'(level_a), 64'd5);
    #2 Reset = 1'b1;
    #1;
    chk("rs_level0", 64'(level_a), 64'd0);
    chk("rs_rdy0",   64'(rdy_a),   64'd0);
    chk("rs_mac_out", 64'({wr_a, data_a, be_a, sop_a, eop_a, err_a}), 64'd0);
    chk("rs_flags",  64'({septy_a, uflow_a, oflow_a, perr_a}), 64'd0);
    @(posedge clk); #1;
    Reset = 1'b0;
    #1;
    chk("rs_rdy_released", 64'(rdy_a), 64'd0);
    @(posedge clk); #1;
    chk("rs_rdy_edge", 64'(rdy_a), 64'd1);
    Tx_mac_wa = 1'b1;
    base_a = qa.size();
    send(32'h90, 2'd0, 1'b1, 1'b0, 1'b0);
    send(32'h91, 2'd1, 1'b0, 1'b1, 1'b0);
    idle(6);
    chk("rs_post_count", 64'(qa.size() - base_a), 64'd2);
    b = beat_a(base_a);
    chk("rs_post_w0", 64'({b.d, b.sop, b.eop}), 64'({32'h90, 1'b1, 1'b0}));
    b = beat_a(base_a + 1);
    chk("rs_post_w1", 64'({b.d, b.be, b.eop, b.err}), 64'({32'h91, 2'd1, 1'b1, 1'b0}));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
